// File: rtl/uart_cdc_pkg.sv
// Shared definitions for the UART transmit arbiter.
//   DATA_W_DEF  - default byte width
//   state_t     - arbiter FSM states (IDLE, LOAD, SEND)
//   clog2_min1  - ceil(log2(n)), never less than 1, for index/counter widths
`timescale 1ns/1ps
package uart_cdc_pkg;

  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    SEND = 2'b10
  } state_t;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick.
// Ports:
//   req_valid [NUM_REQ] - requesters with a byte available
//   last      [GW]      - index of the most recently served requester
//   any_valid           - at least one requester is valid
//   grant     [GW]      - first valid index searching last+1, last+2, ... mod NUM_REQ
`timescale 1ns/1ps
module rr_arbiter
  import uart_cdc_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  localparam int GW      = clog2_min1(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [GW-1:0]      last,
  output logic               any_valid,
  output logic [GW-1:0]      grant
);

  // Walk distances from farthest to nearest so the nearest valid requester
  // after 'last' is the final assignment and therefore wins.
  always_comb begin
    any_valid = 1'b0;
    grant     = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (req_valid[j] && (j == ((int'(last) + k) % NUM_REQ))) begin
          any_valid = 1'b1;
          grant     = GW'(j);
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART TX serializer input between NUM_REQ requesters.
// Round-robin, one byte per grant, per-byte SEND timeout with saturating
// drop counter, and a pulse-stretched activity LED on completed transfers.
// Ports:
//   clk_sys, rst_n        - clock, synchronous active-low reset
//   req_valid/req_data    - per-requester byte offer (slice i at [i*DATA_W +: DATA_W])
//   req_ready             - one-hot accept strobe (LOAD state only)
//   tx_data/tx_valid      - byte to the UART TX, tx_ready is its accept
//   grant_id              - current or last granted requester
//   busy                  - FSM not in IDLE
//   drop_cnt              - saturating count of timed-out bytes
//   led                   - activity LED
`timescale 1ns/1ps
module uart_tx_arbiter
  import uart_cdc_pkg::*;
#(
  parameter  int NUM_REQ  = 2,
  parameter  int DATA_W   = DATA_W_DEF,
  parameter  int TIMEOUT  = 4096,
  parameter  int LED_HOLD = 1000,
  localparam int GW       = clog2_min1(NUM_REQ)
) (
  input  logic                      clk_sys,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [DATA_W-1:0]         tx_data,
  output logic                      tx_valid,
  input  logic                      tx_ready,
  output logic [GW-1:0]             grant_id,
  output logic                      busy,
  output logic [7:0]                drop_cnt,
  output logic                      led
);

  localparam int TW = clog2_min1(TIMEOUT);
  localparam int LW = clog2_min1(LED_HOLD + 1);
  localparam logic [TW-1:0] TO_LAST  = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [LW-1:0] LED_LOAD = LW'(LED_HOLD);

  state_t              state, state_nxt;
  logic [GW-1:0]       last;
  logic [TW-1:0]       to_cnt;
  logic [LW-1:0]       led_cnt;
  logic                any_valid;
  logic [GW-1:0]       pick;
  logic                sel_valid;
  logic [DATA_W-1:0]   sel_data;
  logic                take_grant, do_load, complete, drop, to_inc;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req_valid (req_valid),
    .last      (last),
    .any_valid (any_valid),
    .grant     (pick)
  );

  // Mux out the granted requester's flag and byte.
  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (grant_id == GW'(j)) begin
        sel_valid = req_valid[j];
        sel_data  = req_data[j*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = '0;
    take_grant = 1'b0;
    do_load    = 1'b0;
    complete   = 1'b0;
    drop       = 1'b0;
    to_inc     = 1'b0;
    case (state)
      IDLE: begin
        if (any_valid) begin
          take_grant = 1'b1;
          state_nxt  = LOAD;
        end
      end
      LOAD: begin
        req_ready = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id;
        // A granted requester that withdrew its flag is skipped without
        // moving the pointer.
        if (sel_valid) begin
          do_load   = 1'b1;
          state_nxt = SEND;
        end else begin
          state_nxt = IDLE;
        end
      end
      SEND: begin
        // Completion has priority over a timeout in the same cycle.
        if (tx_ready) begin
          complete  = 1'b1;
          state_nxt = IDLE;
        end else if ((TIMEOUT != 0) && (to_cnt == TO_LAST)) begin
          drop      = 1'b1;
          state_nxt = IDLE;
        end else begin
          to_inc = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      grant_id <= '0;
      last     <= GW'(NUM_REQ - 1);
      tx_data  <= '0;
      to_cnt   <= '0;
      drop_cnt <= '0;
      led_cnt  <= '0;
    end else begin
      if (take_grant) grant_id <= pick;
      if (do_load) begin
        tx_data <= sel_data;
        to_cnt  <= '0;
      end
      if (to_inc) to_cnt <= to_cnt + TW'(1);
      if (complete || drop) last <= grant_id;
      if (drop && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
      if (complete)             led_cnt <= LED_LOAD;
      else if (led_cnt != '0)   led_cnt <= led_cnt - LW'(1);
    end
  end

  assign tx_valid = (state == SEND);
  assign busy     = (state != IDLE);
  assign led      = (led_cnt != '0);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: 2 requesters, default timeout and LED hold.
  logic        rst_na;
  logic [1:0]  rv_a;
  logic [15:0] rd_a;
  logic [1:0]  rr_a;
  logic [7:0]  txd_a;
  logic        txv_a;
  logic        txr_a;
  logic [0:0]  gid_a;
  logic        busy_a;
  logic [7:0]  drop_a;
  logic        led_a;

  uart_tx_arbiter #(.NUM_REQ(2), .DATA_W(8), .TIMEOUT(4096), .LED_HOLD(1000)) dut_a (
    .clk_sys(clk), .rst_n(rst_na), .req_valid(rv_a), .req_data(rd_a), .req_ready(rr_a),
    .tx_data(txd_a), .tx_valid(txv_a), .tx_ready(txr_a), .grant_id(gid_a),
    .busy(busy_a), .drop_cnt(drop_a), .led(led_a));

  // Instance B: 3 requesters, short timeout and LED hold.
  localparam int NB = 3;
  logic        rst_nb;
  logic [2:0]  rv_b;
  logic [23:0] rd_b;
  logic [2:0]  rr_b;
  logic [7:0]  txd_b;
  logic        txv_b;
  logic        txr_b;
  logic [1:0]  gid_b;
  logic        busy_b;
  logic [7:0]  drop_b;
  logic        led_b;

  uart_tx_arbiter #(.NUM_REQ(NB), .DATA_W(8), .TIMEOUT(16), .LED_HOLD(5)) dut_b (
    .clk_sys(clk), .rst_n(rst_nb), .req_valid(rv_b), .req_data(rd_b), .req_ready(rr_b),
    .tx_data(txd_b), .tx_valid(txv_b), .tx_ready(txr_b), .grant_id(gid_b),
    .busy(busy_b), .drop_cnt(drop_b), .led(led_b));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [1:0] vld;
    logic [7:0] d0;
    logic [7:0] d1;
    int         stall;
    int         exp_g;
    logic [7:0] exp_b;
  } vec_t;

  vec_t tbl[8];

  // One full transfer on instance A: offer, expect grant, hold tx_ready low
  // for 'stall' SEND cycles, then expect completion.
  task automatic run_vec(input vec_t v);
    rv_a  = v.vld;
    rd_a  = {v.d1, v.d0};
    txr_a = (v.stall == 0);
    chk("vec_idle_busy", busy_a, 0);
    tick();
    chk("vec_ready", rr_a, 32'd1 << v.exp_g);
    chk("vec_grant", gid_a, v.exp_g);
    tick();
    rv_a = 2'b00;
    for (int k = 0; k <= v.stall; k++) begin
      txr_a = (k >= v.stall);
      chk("vec_txv", txv_a, 1);
      chk("vec_txd", txd_a, v.exp_b);
      tick();
    end
    chk("vec_done_txv", txv_a, 0);
    chk("vec_done_busy", busy_a, 0);
    chk("vec_drop", drop_a, 0);
    chk("vec_led", led_a, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int on_cnt;
    int n;
    int m_last, m_g, m_drops, m_led, m_age;
    logic m_pend, m_inflight, done;
    logic [7:0] m_byte;
    logic [2:0] vsnap, acc;
    logic [23:0] dsnap;
    logic rsnap;

    tbl[0] = '{2'b10, 8'h00, 8'h5A, 20, 1, 8'h5A};
    tbl[1] = '{2'b11, 8'h3C, 8'h5A, 0,  0, 8'h3C};
    tbl[2] = '{2'b11, 8'h3C, 8'h5A, 0,  1, 8'h5A};
    tbl[3] = '{2'b11, 8'h3C, 8'h5A, 0,  0, 8'h3C};
    tbl[4] = '{2'b11, 8'h3C, 8'h5A, 0,  1, 8'h5A};
    tbl[5] = '{2'b10, 8'h00, 8'h77, 2,  1, 8'h77};
    tbl[6] = '{2'b01, 8'h99, 8'h00, 1,  0, 8'h99};
    tbl[7] = '{2'b01, 8'h42, 8'h00, 0,  0, 8'h42};

    rst_na = 1'b0; rv_a = 2'b11; rd_a = 16'h5A3C; txr_a = 1'b1;
    rst_nb = 1'b0; rv_b = '0; rd_b = '0; txr_b = 1'b0;

    // Reset with both requesters valid: every output stays at zero.
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rst_ready", rr_a, 0);
      chk("rst_txv", txv_a, 0);
      chk("rst_txd", txd_a, 0);
      chk("rst_grant", gid_a, 0);
      chk("rst_busy", busy_a, 0);
      chk("rst_drop", drop_a, 0);
      chk("rst_led", led_a, 0);
    end
    rst_na = 1'b1;
    tick();
    chk("first_grant", gid_a, 0);
    chk("first_ready", rr_a, 2'b01);
    tick();
    chk("first_txd", txd_a, 8'h3C);
    rv_a = 2'b00;
    tick();
    chk("first_done", txv_a, 0);

    // Single byte latency and LED stretch.
    rv_a = 2'b01; rd_a = 16'h00A5; txr_a = 1'b1;
    chk("sb_ready_n", rr_a, 0);
    tick();
    chk("sb_ready_n1", rr_a, 2'b01);
    chk("sb_txv_n1", txv_a, 0);
    tick();
    chk("sb_ready_n2", rr_a, 0);
    chk("sb_txv_n2", txv_a, 1);
    chk("sb_txd_n2", txd_a, 8'hA5);
    rv_a = 2'b00;
    tick();
    chk("sb_txv_n3", txv_a, 0);
    chk("sb_txd_hold", txd_a, 8'hA5);
    on_cnt = 0;
    for (int i = 0; i < 1100; i++) begin
      if (led_a) on_cnt++;
      tick();
    end
    chk("sb_led_len", on_cnt, 1000);
    chk("sb_led_off", led_a, 0);

    // Round-robin, backpressure and pointer wrap vectors.
    for (int i = 0; i < 8; i++) run_vec(tbl[i]);

    // Reset in the middle of SEND.
    rv_a = 2'b10; rd_a = 16'hEE11; txr_a = 1'b0;
    tick();
    tick();
    rv_a = 2'b00;
    chk("ms_txv_pre", txv_a, 1);
    rst_na = 1'b0;
    tick();
    chk("ms_txv", txv_a, 0);
    chk("ms_busy", busy_a, 0);
    chk("ms_led", led_a, 0);
    chk("ms_drop", drop_a, 0);
    rst_na = 1'b1; rv_a = 2'b11;
    tick();
    chk("ms_grant", gid_a, 0);
    chk("ms_ready", rr_a, 2'b01);
    tick();
    rv_a = 2'b00;
    for (int i = 0; i < 4; i++) begin
      chk("ms_no_led", led_a, 0);
      tick();
    end
    rst_na = 1'b0;
    tick();
    rst_na = 1'b1;

    // Timeout on instance B.
    tick();
    rst_nb = 1'b1;
    rv_b = 3'b001; rd_b = 24'h0000C3;
    tick();
    tick();
    rv_b = 3'b000;
    n = 0;
    while (txv_b && n < 40) begin
      n++;
      tick();
    end
    chk("to_len", n, 16);
    chk("to_drop1", drop_b, 1);
    chk("to_busy", busy_b, 0);
    rv_b = 3'b001;
    for (int i = 0; i < 299 * 18; i++) tick();
    rv_b = 3'b000;
    for (int i = 0; i < 20; i++) tick();
    chk("to_sat", drop_b, 255);
    chk("to_led", led_b, 0);

    // Randomized traffic on instance B against a transaction model.
    rst_nb = 1'b0; rv_b = '0; rd_b = '0; txr_b = 1'b0;
    tick();
    tick();
    rst_nb = 1'b1;
    m_last = NB - 1; m_g = 0; m_drops = 0; m_led = 0; m_age = 0;
    m_pend = 1'b0; m_inflight = 1'b0; m_byte = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int j = 0; j < NB; j++) begin
        if (!rv_b[j] && ($urandom_range(0, 3) == 0)) begin
          rv_b[j] = 1'b1;
          rd_b[j*8 +: 8] = 8'($urandom);
        end
      end
      txr_b = (cyc < 2000) ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 19) == 0);

      chk("rnd_ready", rr_b, m_pend ? (32'd1 << m_g) : 32'd0);
      chk("rnd_txv", txv_b, m_inflight);
      if (m_inflight) chk("rnd_txd", txd_b, m_byte);
      chk("rnd_busy", busy_b, m_pend || m_inflight);
      chk("rnd_grant", gid_b, m_g);
      chk("rnd_drop", drop_b, m_drops);
      chk("rnd_led", led_b, m_led != 0);

      vsnap = rv_b; dsnap = rd_b; rsnap = txr_b;
      acc = rv_b & rr_b;
      done = 1'b0;
      if (m_pend) begin
        m_byte = dsnap[m_g*8 +: 8];
        m_inflight = 1'b1;
        m_age = 0;
        m_pend = 1'b0;
      end else if (m_inflight) begin
        if (rsnap) begin
          m_inflight = 1'b0;
          done = 1'b1;
          m_last = m_g;
        end else if (m_age == 15) begin
          m_inflight = 1'b0;
          m_last = m_g;
          if (m_drops < 255) m_drops++;
        end else begin
          m_age++;
        end
      end else if (vsnap != 0) begin
        for (int k = NB; k >= 1; k--) begin
          if (vsnap[(m_last + k) % NB]) m_g = (m_last + k) % NB;
        end
        m_pend = 1'b1;
      end
      if (done) m_led = 5;
      else if (m_led > 0) m_led--;

      tick();
      for (int j = 0; j < NB; j++) begin
        if (acc[j]) begin
          if ($urandom_range(0, 1) == 0) rd_b[j*8 +: 8] = 8'($urandom);
          else rv_b[j] = 1'b0;
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmit path (tx_data/tx_valid into the UART TX serializer) between NUM_REQ requesters in the clk_sys domain.
- Requesters include the CDC receive-echo channel and the status/command channel.
- Uses round-robin arbitration, one byte per grant, with a per-byte transmit timeout and drop counting.
- Drives the activity LED with a pulse-stretched indication of completed transfers.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- DATA_W, 8, byte width.
- TIMEOUT, 4096, SEND-state cycles before the byte is dropped; 0 disables the timeout.
- LED_HOLD, 1000, clk_sys cycles the LED stays on after each completed transfer; must be at least 1.

Ports:
- clk_sys  in  1  system clock; all logic is in this one clock domain.
- rst_n  in  1  synchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester byte-available flag.
- req_data  in  NUM_REQ*DATA_W  requester i's byte is bits [i*DATA_W +: DATA_W].
- req_ready  out  NUM_REQ  one-hot accept strobe.
- tx_data  out  DATA_W  byte presented to the UART TX.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  UART TX accepts the byte this cycle.
- grant_id  out  $clog2(NUM_REQ)  index of the current or last granted requester.
- busy  out  1  high whenever state is not IDLE.
- drop_cnt  out  8  saturating count of timed-out bytes.
- led  out  1  activity LED.

Behaviour:
- All registers update on the rising edge of clk_sys.
- Reset: when rst_n is low at a clock edge, on any state:
  - state goes to IDLE; any in-flight byte is discarded with no completion and no drop count.
  - req_ready=0, tx_valid=0, tx_data=0, grant_id=0, busy=0, drop_cnt=0, led=0.
  - The LED counter is cleared.
  - The round-robin pointer last=NUM_REQ-1, so requester 0 has first priority.
- Handshake rules:
  - A requester holds req_valid and req_data stable until req_ready is sampled high.
  - A transfer into the arbiter occurs on a cycle where req_valid[g] and req_ready[g] are both high.
  - Downstream, a byte transfers on a cycle where tx_valid and tx_ready are both high.
- FSM state IDLE:
  - If any req_valid bit is high, pick g = the first set bit searching last+1, last+2, ... modulo NUM_REQ.
  - Register grant_id=g and go to LOAD. Otherwise stay in IDLE.
- FSM state LOAD (one cycle):
  - req_ready = one-hot(grant_id), combinationally decoded from state and grant_id.
  - If req_valid[grant_id]=1: capture req_data slice into tx_data, set tx_valid=1, clear the timeout counter, go to SEND.
  - If req_valid[grant_id]=0 (protocol violation): no capture, no pointer update, go to IDLE.
- FSM state SEND:
  - tx_valid=1; tx_data is held constant.
  - If tx_ready=1: the transfer completes. tx_valid goes to 0, last=grant_id, the LED counter loads LED_HOLD, go to IDLE.
  - Else if TIMEOUT!=0 and the timeout counter equals TIMEOUT-1: drop the byte. tx_valid goes to 0, drop_cnt increments (holds at 255), last=grant_id, go to IDLE.
  - Else the timeout counter increments.
  - tx_ready and timeout in the same cycle: completion wins and no drop is counted.
- Latency:
  - req_valid high in IDLE cycle N gives req_ready in cycle N+1 and tx_valid from cycle N+2.
  - Best-case throughput is one byte per 3 cycles (IDLE, LOAD, SEND with tx_ready=1).
- Fairness:
  - A requester that keeps req_valid high is never granted twice in a row while another requester is valid.
  - With all NUM_REQ requesters valid continuously, grants cycle 0,1,...,NUM_REQ-1,0,...
- Pointer wrap: last=NUM_REQ-1 wraps the search to start at 0.
- grant_id holds its value in IDLE.
- LED:
  - The LED counter decrements to 0 each cycle; led = (counter != 0).
  - A new completion reloads LED_HOLD.
- tx_data holds its last value after completion; only tx_valid qualifies it.

Decomposition:
- Package uart_cdc_pkg holds:
  - DATA_W default;
  - the state enum (IDLE, LOAD, SEND), encoded 2'b00, 2'b01, 2'b10;
  - a clog2 helper for the grant and counter widths.
- One sub-module, rr_arbiter:
  - Parameter NUM_REQ.
  - Inputs req_valid and last; outputs any_valid and grant index.
  - Purely combinational round-robin pick.
- The FSM, timeout counter, drop counter, pointer register and LED stretcher stay in uart_tx_arbiter.

Test Plan:
- Reset/idle: hold rst_n=0 for 5 cycles with req_valid=2'b11. Every output must be 0 during reset; grant_id=0 is the first grant after release.
- Single byte: req0 with data 8'hA5, tx_ready tied to 1. req_ready[0] is high exactly one cycle (N+1), tx_data=8'hA5 with tx_valid for one cycle (N+2), led rises and stays high 1000 cycles.
- Round-robin: req_valid=2'b11 held continuously, req0=8'h3C, req1=8'h5A, tx_ready=1. tx_data sequence is 3C,5A,3C,5A; grant_id alternates 0,1,0,1.
- Backpressure: byte 8'h5A with tx_ready held 0 for 20 cycles, then 1. tx_valid stays high and tx_data stays 8'h5A for 21 cycles, then one completion with drop_cnt=0.
- Timeout: TIMEOUT=16 and tx_ready=0 forever. tx_valid drops after 16 SEND cycles, drop_cnt=1, and busy returns to 0. Repeat 300 bytes: drop_cnt saturates at 255.
- Reset mid-SEND: assert rst_n=0 for 1 cycle during SEND. tx_valid=0 next cycle, no LED pulse, drop_cnt=0, and the next grant goes to req0.
